// File: rtl/uart_mmio_tx_if.sv
// uart_mmio_tx_if: MMIO write/ready handshake between the memory stage and the UART transmitter.
//   mmio_wea   master->slave  write strobe
//   mmio_dat   master->slave  32-bit write data, low byte is the character
//   mmio_read  slave->master  1 = FIFO not full, a write this cycle is accepted
interface uart_mmio_tx_if;
    logic        mmio_wea;
    logic [31:0] mmio_dat;
    logic        mmio_read;
    modport master (output mmio_wea, mmio_dat, input mmio_read);
    modport slave  (input mmio_wea, mmio_dat, output mmio_read);
endinterface

// File: rtl/uart_mmio_tx.sv
// uart_mmio_tx: MMIO-fed TX FIFO plus 8N1 UART serialiser.
//   clk         system clock, posedge
//   Rst         synchronous active-high reset
//   bus         slave side of uart_mmio_tx_if (mmio_wea, mmio_dat in; mmio_read out)
//   tx          serial out, idle high, registered
//   tx_busy     frame in flight or bytes queued
//   fifo_count  bytes queued, not counting the byte in the shifter
//   overflow    sticky flag: a write was dropped because the FIFO was full
module uart_mmio_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                            clk,
    input  logic                            Rst,
    uart_mmio_tx_if.slave                   bus,
    output logic                            tx,
    output logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            full, push, pop, bit_end;
    logic            unused_hi;

    assign unused_hi = ^bus.mmio_dat[31:8];

    // Fullness is judged before any same-cycle pop, so a write to a full FIFO is dropped even when IDLE pops.
    assign full    = count_q == CW'(FIFO_DEPTH);
    assign push    = bus.mmio_wea && !full;
    assign pop     = state_q == IDLE && count_q != '0;
    assign bit_end = baud_q == BW'(CLKS_PER_BIT - 1);

    assign bus.mmio_read = !full;
    assign tx            = tx_q;
    assign tx_busy       = state_q != IDLE || count_q != '0;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;

    always_comb begin
        wr_d       = push ? wr_q + 1'b1 : wr_q;
        rd_d       = pop ? rd_q + 1'b1 : rd_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        overflow_d = overflow_q || (bus.mmio_wea && full);
        state_d    = state_q;
        baud_d     = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        // tx follows the current state one cycle later, keeping the pin glitch-free.
        tx_d       = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
        case (state_q)
            IDLE:  if (pop) begin
                       state_d = START;
                       shift_d = mem_q[rd_q];
                   end
            START: if (bit_end) begin
                       state_d = DATA;
                       bit_d   = '0;
                   end
            DATA:  if (bit_end) begin
                       shift_d = shift_q >> 1;
                       bit_d   = bit_q + 1'b1;
                       state_d = bit_q == 3'd7 ? STOP : DATA;
                   end
            STOP:  if (bit_end) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= bus.mmio_dat[7:0];
    end
endmodule

// File: tb/tb_uart_mmio_tx.sv
// tb_uart_mmio_tx: directed self-checking bench for uart_mmio_tx with 4 clocks per bit and a 4-deep FIFO.
module tb_uart_mmio_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       Rst = 1'b1;
    logic       tx, tx_busy, overflow;
    logic [2:0] fifo_count;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    int         w;
    logic [8:0] rx_q [$];
    int         fall_q [$];

    uart_mmio_tx_if bus ();

    uart_mmio_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .Rst(Rst), .bus(bus), .tx(tx), .tx_busy(tx_busy),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: a falling edge seen at the negedge after posedge E is a start bit launched at E;
    // data bit i is sampled after E+6+4i, stop after E+38. Frames cut by Rst are discarded.
    initial begin : mon
        logic       prev;
        logic [8:0] f;
        int         fc;
        bit         ok;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!Rst && prev === 1'b1 && tx === 1'b0) begin
                fc = cyc;
                ok = 1'b1;
                f  = '0;
                for (int k = 1; k <= 38 && ok; k++) begin
                    @(negedge clk);
                    if (Rst) ok = 1'b0;
                    else if (k >= 6 && k <= 34 && (k - 6) % 4 == 0) f[(k - 6) / 4] = tx;
                    else if (k == 38) f[8] = tx;
                end
                if (ok) begin
                    rx_q.push_back(f);
                    fall_q.push_back(fc);
                end
            end
            prev = tx;
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [31:0] d);
        bus.mmio_wea = 1'b1;
        bus.mmio_dat = d;
        tick(1);
        bus.mmio_wea = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick(2);
        Rst = 1'b0;
    endtask

    // Waits (bounded) for the next decoded frame; checks stop bit + byte and the start-bit edge cycle.
    task automatic expect_frame(string tag, logic [7:0] b, int fall_exp);
        int t = 0;
        while (rx_q.size() == 0 && t < 2000) begin
            tick(1);
            t++;
        end
        if (rx_q.size() == 0) check({tag, "_timeout"}, 0, 1);
        else begin
            check(tag, rx_q.pop_front(), {1'b1, b});
            check({tag, "_fall"}, fall_q.pop_front(), fall_exp);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.mmio_wea = 1'b0;
        bus.mmio_dat = '0;
        do_reset();
        check("rst_tx", tx, 1);
        check("rst_ready", bus.mmio_read, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);

        // Single byte, upper data bits set and ignored.
        wr(32'hFFFF_FF55);
        w = cyc;
        check("one_count", fifo_count, 1);
        check("one_tx_idle", tx, 1);
        tick(1);
        check("one_busy", tx_busy, 1);
        check("one_popped", fifo_count, 0);
        tick(39);
        check("one_busy_stop", tx_busy, 1);
        tick(1);
        check("one_busy_done", tx_busy, 0);
        expect_frame("one_b55", 8'h55, w + 2);

        // Burst of five on consecutive cycles: one goes to the shifter, four fill the FIFO.
        tick(5);
        for (int i = 1; i <= 5; i++) begin
            wr(32'(i));
            if (i == 1) w = cyc;
        end
        check("burst_count", fifo_count, 4);
        check("burst_ready", bus.mmio_read, 0);
        check("burst_ovf", overflow, 0);
        for (int i = 0; i < 5; i++) expect_frame($sformatf("burst_%0d", i + 1), 8'(i + 1), w + 2 + 41 * i);
        check("burst_ovf_end", overflow, 0);

        // Six back-to-back writes: the sixth hits a full FIFO and is dropped.
        tick(5);
        for (int i = 0; i < 6; i++) begin
            wr(32'h11 + 32'(i));
            if (i == 0) w = cyc;
            if (i == 4) begin
                check("ovf_full_ready", bus.mmio_read, 0);
                check("ovf_pre", overflow, 0);
            end
        end
        check("ovf_set", overflow, 1);
        check("ovf_count", fifo_count, 4);
        for (int i = 0; i < 5; i++) expect_frame($sformatf("ovf_%0d", i), 8'h11 + 8'(i), w + 2 + 41 * i);
        tick(60);
        check("ovf_no_extra", rx_q.size(), 0);
        check("ovf_sticky", overflow, 1);
        check("ovf_idle", tx_busy, 0);

        // Full FIFO, write lands on the IDLE pop cycle: dropped, count 4->3.
        do_reset();
        check("fp_ovf_clear", overflow, 0);
        wr(32'h21);
        w = cyc;
        for (int i = 2; i <= 5; i++) wr(32'h20 + 32'(i));
        tick(37);
        check("fp_full", fifo_count, 4);
        check("fp_ready", bus.mmio_read, 0);
        wr(32'h99);
        check("fp_count", fifo_count, 3);
        check("fp_ovf", overflow, 1);
        check("fp_ready_after", bus.mmio_read, 1);
        for (int i = 0; i < 5; i++) expect_frame($sformatf("fp_%0d", i), 8'h21 + 8'(i), w + 2 + 41 * i);
        tick(60);
        check("fp_no_extra", rx_q.size(), 0);

        // Reset during data bit 3 of 8'hA5 with two bytes queued.
        wr(32'hA5);
        w = cyc;
        wr(32'h5A);
        wr(32'h3C);
        check("mid_count", fifo_count, 2);
        tick(17);
        check("mid_bit3", tx, 0);
        Rst = 1'b1;
        tick(1);
        Rst = 1'b0;
        check("mid_tx", tx, 1);
        check("mid_count0", fifo_count, 0);
        check("mid_busy", tx_busy, 0);
        check("mid_ready", bus.mmio_read, 1);
        tick(200);
        check("mid_no_frames", rx_q.size(), 0);
        check("mid_tx_idle", tx, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
